// File: rtl/fwd_adapter_pkg.sv
// Shared definitions for the forwarder-side P3 agent adapter.
// State encoding and the in-flight counter sizing helper.
package fwd_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } fwdState_t;

  // Enough bits to count 0..bufLat outstanding reads.
  function automatic int inflightWidth(input int bufLat);
    return $clog2(bufLat + 1);
  endfunction

endpackage

// File: rtl/fwd_adapter_rd_vld_pipe.sv
// Read-valid delay line matching the P3 read latency, plus a count of
// reads issued whose data has not yet come back.
module fwd_adapter_rd_vld_pipe #(
  parameter int BUF_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_en,
  output logic             o_vld,
  output logic [CNT_W-1:0] o_inflight
);

  logic [BUF_LAT-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;

  generate
    if (BUF_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_shift <= '0;
        else     r_shift <= i_rd_en;
      end
    end else begin : g_latN
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_shift <= '0;
        else     r_shift <= {r_shift[BUF_LAT-2:0], i_rd_en};
      end
    end
  endgenerate

  assign o_vld = r_shift[BUF_LAT-1];

  // Issue and return in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_rd_en && !o_vld) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (!i_rd_en && o_vld) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_inflight = r_cnt;

endmodule

// File: rtl/fwd_adapter.sv
// Forwarder-side P3 adapter: offers ready buffers, turns forwarder word reads
// into P3 half-word reads with qualified valid, and drains before release.
module fwd_adapter
  import fwd_adapter_pkg::*;
#(
  parameter int FWD_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int PLEN_WIDTH     = 32,
  parameter int BUF_LAT        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FWD_ADDR_WIDTH-1:0] fwd_addr,
  input  logic                    fwd_rd_en,
  input  logic                    fwd_done,
  input  logic                    rdy_for_fwd_ack,
  output logic [DATA_WIDTH-1:0]   fwd_rd_data,
  output logic                    fwd_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]   fwd_byte_length,
  output logic                    fwd_done_ack,
  output logic                    rdy_for_fwd,
  output logic [FWD_ADDR_WIDTH:0] addr,
  output logic                    rd_en,
  output logic                    done,
  output logic                    rdy_ack,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [PLEN_WIDTH-1:0]   byte_length,
  input  logic                    done_ack,
  input  logic                    rdy
);

  localparam int CNT_W = inflightWidth(BUF_LAT);

  fwdState_t             r_state;
  fwdState_t             w_nextState;
  logic                  r_done;
  logic                  r_fwdDoneAck;
  logic [PLEN_WIDTH-1:0] r_byteLength;
  logic                  w_rdEn;
  logic                  w_vld;
  logic                  w_accept;
  logic                  w_drained;
  logic [CNT_W-1:0]      w_inflight;

  assign addr        = {fwd_addr, 1'b0};
  assign fwd_rd_data = rd_data;
  assign w_rdEn      = fwd_rd_en && (r_state == ST_ACTIVE);
  assign rd_en       = w_rdEn;
  assign rdy_for_fwd = (r_state == ST_IDLE) && rdy;
  assign w_accept    = rdy_for_fwd && rdy_for_fwd_ack;
  assign rdy_ack     = w_accept;

  fwd_adapter_rd_vld_pipe #(
    .BUF_LAT (BUF_LAT),
    .CNT_W   (CNT_W)
  ) u_rdVldPipe (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (w_rdEn),
    .o_vld      (w_vld),
    .o_inflight (w_inflight)
  );

  assign fwd_rd_data_vld = w_vld;

  // No reads are issued in DRAIN, so a returning valid on the last one empties it.
  assign w_drained = (w_inflight == '0) || ((w_inflight == CNT_W'(1)) && w_vld);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_nextState = ST_ACTIVE;
      ST_ACTIVE: if (fwd_done)  w_nextState = ST_DRAIN;
      ST_DRAIN:  if (w_drained) w_nextState = ST_DONE;
      ST_DONE:   if (done_ack)  w_nextState = ST_IDLE;
      default:                  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byteLength <= '0;
      r_done       <= 1'b0;
      r_fwdDoneAck <= 1'b0;
    end else begin
      if (w_accept) r_byteLength <= byte_length;
      if ((r_state == ST_DRAIN) && w_drained)    r_done <= 1'b1;
      else if ((r_state == ST_DONE) && done_ack) r_done <= 1'b0;
      r_fwdDoneAck <= (r_state == ST_DONE) && done_ack;
    end
  end

  assign fwd_byte_length = r_byteLength;
  assign done            = r_done;
  assign fwd_done_ack    = r_fwdDoneAck;

endmodule

// File: doc/fwd_adapter.md
Name: fwd_adapter

Overview:
Forwarder-side agent adapter for the P3 packet filter core. It is the read-out counterpart of the snooper write adapter. It hands a ready, accepted packet buffer to the forwarder, translates forwarder word reads into P3 read-port accesses, and tracks read latency so the forwarder gets a qualified data-valid. It drains in-flight reads before completing the done/done_ack handshake back to P3.

Parameters:
FWD_ADDR_WIDTH, 8, forwarder word-address width (DATA_WIDTH-bit words)
DATA_WIDTH, 64, read data width
PLEN_WIDTH, 32, packet byte-length width
BUF_LAT, 2, P3 read latency in cycles from rd_en to rd_data (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fwd_addr  in  FWD_ADDR_WIDTH  forwarder word read address
fwd_rd_en  in  1  forwarder read request
fwd_done  in  1  forwarder finished with buffer (level, held until fwd_done_ack)
rdy_for_fwd_ack  in  1  forwarder accepts offered buffer
fwd_rd_data  out  DATA_WIDTH  read data to forwarder
fwd_rd_data_vld  out  1  fwd_rd_data valid this cycle
fwd_byte_length  out  PLEN_WIDTH  latched packet length of accepted buffer
fwd_done_ack  out  1  one-cycle pulse: P3 acknowledged done
rdy_for_fwd  out  1  buffer available to forwarder
addr  out  FWD_ADDR_WIDTH+1  P3 read address
rd_en  out  1  P3 read enable
done  out  1  buffer release request to P3
rdy_ack  out  1  acceptance of offered buffer to P3
rd_data  in  DATA_WIDTH  P3 read data
byte_length  in  PLEN_WIDTH  P3 packet length, valid while rdy
done_ack  in  1  P3 acknowledges done
rdy  in  1  P3 has a buffer ready for forwarding

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst. All registered state clears on reset: state=IDLE, valid shift register=0, in-flight count=0, fwd_byte_length=0, done=0, fwd_done_ack=0.
- addr = {fwd_addr, 1'b0}, combinational. P3 memory is half-word addressed.
- rd_en = fwd_rd_en && state==ACTIVE. Reads issued in any other state are dropped and produce no valid.
- fwd_rd_data = rd_data, combinational pass-through.
- fwd_rd_data_vld = bit BUF_LAT-1 of a BUF_LAT-deep shift register fed with rd_en. A read in cycle t gives valid in cycle t+BUF_LAT. Back-to-back reads give back-to-back valids.
- In-flight count: +1 on rd_en, -1 on valid out, unchanged when both occur. Width is clog2(BUF_LAT+1). It never exceeds BUF_LAT.
- FSM:
  - IDLE:
    - rdy_for_fwd = rdy; rdy_ack = rdy_for_fwd_ack && rdy (combinational).
    - On rdy && rdy_for_fwd_ack: latch byte_length into fwd_byte_length, go to ACTIVE.
  - ACTIVE:
    - Reads pass. rdy_for_fwd = 0.
    - On fwd_done: go to DRAIN. A read issued in the same cycle as fwd_done is still performed.
  - DRAIN:
    - rd_en forced 0.
    - When in-flight count == 0, or will be 0 next cycle, go to DONE.
  - DONE:
    - done = 1 (registered) and held until done_ack.
    - On done_ack: done = 0, fwd_done_ack pulses 1 on the next cycle, go to IDLE.
- rdy_for_fwd is 0 in every state other than IDLE.
- done_ack outside DONE is ignored.
- If fwd_done is still high on return to IDLE it is not re-acted on. Release only takes effect from ACTIVE.
- fwd_byte_length holds its value until the next acceptance.
- Reset mid-operation: outputs clear immediately. Pending valids are discarded. P3 must be reset together with this block.

Decomposition:
- Shared package (p3 agent package) holds:
  - FSM state encoding: IDLE, ACTIVE, DRAIN, DONE (2 bits).
  - Helper constant for the in-flight counter width.
- One natural sub-module, rd_vld_pipe: a parameterised BUF_LAT-deep valid shift register with async reset that also outputs the in-flight count.

Test Plan:
- Reset checks:
  - Assert rst asynchronously mid-ACTIVE with 2 reads in flight: all outputs go 0 with no clock edge, and no fwd_rd_data_vld follows.
  - Idle pass-through: rdy=0 gives rdy_for_fwd=0; rdy=1 gives rdy_for_fwd=1.
- Acceptance: rdy=1, byte_length=60, rdy_for_fwd_ack=1 -> rdy_ack=1 that cycle, fwd_byte_length=60 the next, then rdy_for_fwd=0.
- Read latency, BUF_LAT=2: reads at fwd_addr 0,1,2 on consecutive cycles -> addr=0,2,4 with rd_en=1; fwd_rd_data_vld high exactly 2 cycles later for 3 consecutive cycles, data matching model memory.
- Drain ordering: last read and fwd_done in the same cycle -> done rises only after the final valid; a read during DRAIN gives rd_en=0.
- Done handshake: done_ack delayed 5 cycles -> done held high 5 cycles; fwd_done_ack pulses once for 1 cycle; state returns to IDLE and a new rdy is offered.
- Reads in IDLE: fwd_rd_en=1 with no accepted buffer -> rd_en=0 and no fwd_rd_data_vld.
